fixed_to_float: RTL and testbench



---
 rtl/fixed_to_float.sv | 157 +++++++++++++++
 tb/tb_fixed_to_float.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float.sv
// fixed_to_float: converts a signed two's-complement fixed-point word with
// FRAC_BITS fractional bits into an IEEE-754 single-precision word.
// The magnitude is normalised one left shift per cycle while a biased
// exponent counts down. The result is then packed in a separate cycle.
// The Begin/ACK/FSM-reset handshake matches the other conversion blocks.
//
// Optional build macro FIXED_TO_FLOAT_ROUND_EN:
//   defined   -> the packed mantissa is rounded to nearest-even
//   undefined -> the packed mantissa is truncated (default)
module fixed_to_float #(
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RST_FSM_FX,
  input  logic        Begin_FSM_FX,
  input  logic [31:0] FIXED,
  output logic [31:0] FLOAT,
  output logic        ACK_FX
);

  // Biased exponent of the MSB position of a 32-bit word with FRAC_BITS
  // fractional bits. Over the legal FRAC_BITS range it stays within 96..159.
  localparam logic [8:0] EXP_INIT = 9'(127 + 31 - FRAC_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        sgn_q,   sgn_d;
  logic [31:0] m_q,     m_d;
  logic [8:0]  exp_q,   exp_d;
  logic [31:0] float_q, float_d;

  // Unsigned magnitude of a two's-complement word. 32'h80000000 maps to
  // itself, which is its correct magnitude when it is read as unsigned.
  function automatic logic [31:0] abs_mag(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Packs a normalised magnitude (m[31] set) into single-precision format.
  // The hidden bit m[31] is dropped.
`ifdef FIXED_TO_FLOAT_ROUND_EN
  function automatic logic [31:0] pack_float(input logic       sgn,
                                             input logic [8:0]  e,
                                             input logic [31:0] m);
    logic        round_up;
    logic [23:0] mant_sum;
    logic [7:0]  e_out;
    // Round to nearest-even: guard = m[7], sticky = |m[6:0], lsb = m[8].
    round_up = m[7] & ((|m[6:0]) | m[8]);
    mant_sum = {1'b0, m[30:8]} + {23'd0, round_up};
    // A carry out of an all-ones mantissa leaves the mantissa at zero
    // and moves the value to the next binade.
    e_out    = e[7:0] + {7'd0, mant_sum[23]};
    return {sgn, e_out, mant_sum[22:0]};
  endfunction
`else
  function automatic logic [31:0] pack_float(input logic       sgn,
                                             input logic [8:0]  e,
                                             input logic [31:0] m);
    // Truncate: the low byte of the normalised magnitude is discarded.
    return {sgn, e[7:0], m[30:8]};
  endfunction
`endif

  // Next-state and datapath logic for the IDLE/NORM/PACK/DONE sequence.
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    m_d     = m_q;
    exp_d   = exp_q;
    float_d = float_q;

    case (state_q)
      ST_IDLE: begin
        if (Begin_FSM_FX) begin
          sgn_d   = FIXED[31];
          m_d     = abs_mag(FIXED);
          exp_d   = EXP_INIT;
          state_d = ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_NORM: begin
        if (m_q == 32'd0) begin
          // A zero operand gives +0, never -0. It goes through PACK so that
          // the shortest conversion takes the same two cycles as lz = 0.
          float_d = 32'h0000_0000;
          state_d = ST_PACK;
        end else if (m_q[31]) begin
          state_d = ST_PACK;
        end else begin
          m_d     = {m_q[30:0], 1'b0};
          exp_d   = exp_q - 9'd1;
          state_d = ST_NORM;
        end
      end

      ST_PACK: begin
        if (m_q == 32'd0) begin
          float_d = 32'h0000_0000;
        end else begin
          float_d = pack_float(sgn_q, exp_q, m_q);
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // A Begin in this state is ignored, even in the acknowledge cycle.
        if (RST_FSM_FX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sgn_q   <= 1'b0;
      m_q     <= 32'd0;
      exp_q   <= 9'd0;
      float_q <= 32'd0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      m_q     <= m_d;
      exp_q   <= exp_d;
      float_q <= float_d;
    end
  end

  // ACK is decoded from the state register, so it has no input path.
  assign ACK_FX = (state_q == ST_DONE);
  assign FLOAT  = float_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed testbench for fixed_to_float (FRAC_BITS = 16). The expected
// values are worked out by hand from the IEEE-754 encoding of each operand.
module tb_fixed_to_float;

  logic        CLK;
  logic        RST;
  logic        RST_FSM_FX;
  logic        Begin_FSM_FX;
  logic [31:0] FIXED;
  logic [31:0] FLOAT;
  logic        ACK_FX;

  int pass_cnt  = 0;
  int check_cnt = 0;

  fixed_to_float #(.FRAC_BITS(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RST_FSM_FX   (RST_FSM_FX),
    .Begin_FSM_FX (Begin_FSM_FX),
    .FIXED        (FIXED),
    .FLOAT        (FLOAT),
    .ACK_FX       (ACK_FX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drives a one-cycle Begin pulse. It returns at the negedge after the
  // sampling edge, which is zero edges after that edge.
  task automatic launch(input logic [31:0] v);
    @(negedge CLK);
    FIXED        = v;
    Begin_FSM_FX = 1'b1;
    @(negedge CLK);
    Begin_FSM_FX = 1'b0;
    FIXED        = 32'hDEAD_BEEF;
  endtask

  // Counts further rising edges until ACK_FX is seen. It returns -1 if the
  // bound runs out.
  task automatic wait_ack(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge CLK);
      if (ACK_FX === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Acknowledges the result so that the FSM returns to IDLE.
  task automatic release_ack();
    @(negedge CLK);
    RST_FSM_FX = 1'b1;
    @(negedge CLK);
    RST_FSM_FX = 1'b0;
  endtask

  task automatic test_reset();
    RST          = 1'b1;
    RST_FSM_FX   = 1'b0;
    Begin_FSM_FX = 1'b0;
    FIXED        = 32'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_cnt++;
    if (FLOAT !== 32'h0000_0000) $display("FAIL reset_float got %h want %h", FLOAT, 32'h0);
    else pass_cnt++;
    check_cnt++;
    if (ACK_FX !== 1'b0) $display("FAIL reset_ack got %b want 0", ACK_FX);
    else pass_cnt++;
  endtask

  // Converts one operand and checks the latency, the result and the
  // release to IDLE, which must keep the last FLOAT.
  task automatic test_convert(input string name, input logic [31:0] v,
                              input logic [31:0] exp_f, input int exp_lat);
    int lat;
    launch(v);
    check_cnt++;
    if (ACK_FX !== 1'b0) $display("FAIL %s_ack_early got %b want 0", name, ACK_FX);
    else pass_cnt++;
    wait_ack(40, lat);
    check_cnt++;
    if (lat !== exp_lat) $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    else pass_cnt++;
    check_cnt++;
    if (FLOAT !== exp_f) $display("FAIL %s_float got %h want %h", name, FLOAT, exp_f);
    else pass_cnt++;
    release_ack();
    check_cnt++;
    if (ACK_FX !== 1'b0 || FLOAT !== exp_f)
      $display("FAIL %s_release got ack=%b float=%h want ack=0 float=%h", name, ACK_FX, FLOAT, exp_f);
    else pass_cnt++;
  endtask

  task automatic test_ack_hold();
    int lat;
    launch(32'h0001_0000);
    wait_ack(40, lat);
    repeat (5) @(negedge CLK);
    check_cnt++;
    if (ACK_FX !== 1'b1 || FLOAT !== 32'h3F80_0000)
      $display("FAIL ack_hold got ack=%b float=%h want ack=1 float=3f800000", ACK_FX, FLOAT);
    else pass_cnt++;
    release_ack();
  endtask

  task automatic test_begin_during_norm();
    int lat;
    launch(32'h0001_0000);
    repeat (3) @(negedge CLK);
    FIXED        = 32'hFFFF_0000;
    Begin_FSM_FX = 1'b1;
    @(negedge CLK);
    Begin_FSM_FX = 1'b0;
    wait_ack(40, lat);
    check_cnt++;
    if (lat + 4 !== 17) $display("FAIL rebegin_latency got %0d want 17", lat + 4);
    else pass_cnt++;
    check_cnt++;
    if (FLOAT !== 32'h3F80_0000) $display("FAIL rebegin_float got %h want 3f800000", FLOAT);
    else pass_cnt++;
    release_ack();
  endtask

  task automatic test_ack_with_begin();
    int lat;
    launch(32'hFFFF_0000);
    wait_ack(40, lat);
    @(negedge CLK);
    RST_FSM_FX   = 1'b1;
    Begin_FSM_FX = 1'b1;
    FIXED        = 32'h8000_0000;
    @(negedge CLK);
    RST_FSM_FX   = 1'b0;
    Begin_FSM_FX = 1'b0;
    check_cnt++;
    if (ACK_FX !== 1'b0) $display("FAIL ack_begin_idle got %b want 0", ACK_FX);
    else pass_cnt++;
    repeat (6) @(negedge CLK);
    check_cnt++;
    if (ACK_FX !== 1'b0 || FLOAT !== 32'hBF80_0000)
      $display("FAIL ack_begin_noconv got ack=%b float=%h want ack=0 float=bf800000", ACK_FX, FLOAT);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int lat;
    launch(32'h0001_0000);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_cnt++;
    if (FLOAT !== 32'h0000_0000 || ACK_FX !== 1'b0)
      $display("FAIL midrst got ack=%b float=%h want ack=0 float=00000000", ACK_FX, FLOAT);
    else pass_cnt++;
    wait_ack(20, lat);
    check_cnt++;
    if (lat !== -1) $display("FAIL midrst_idle got ack after %0d want none", lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_convert("one",     32'h0001_0000, 32'h3F80_0000, 17);
    test_convert("neg_one", 32'hFFFF_0000, 32'hBF80_0000, 17);
    test_convert("zero",    32'h0000_0000, 32'h0000_0000, 2);
    test_convert("min",     32'h8000_0000, 32'hC700_0000, 2);
    test_convert("onehalf", 32'h0001_8000, 32'h3FC0_0000, 17);
    test_convert("lsb",     32'h0000_0001, 32'h3780_0000, 33);
`ifdef FIXED_TO_FLOAT_ROUND_EN
    test_convert("max",     32'h7FFF_FFFF, 32'h4700_0000, 3);
`else
    test_convert("max",     32'h7FFF_FFFF, 32'h46FF_FFFF, 3);
`endif
    test_ack_hold();
    test_begin_during_norm();
    test_ack_with_begin();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
